// File: rtl/vert_ucode_quicksort_unload.sv
// Unload engine for the banked quicksort: grants one SORTED bank round-robin, streams its entries out.
// Optional order checker enabled by defining VERT_UCODE_QUICKSORT_UNLOAD_CHECK_EN.
module vert_ucode_quicksort_unload #(
    parameter int N      = 16,
    parameter int W      = 32,
    parameter int BANK_N = 2,
    localparam int AW    = $clog2(N),
    localparam int NW    = $clog2(N) + 1,
    localparam int BW    = (BANK_N > 1) ? $clog2(BANK_N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BANK_N-1:0]    sorted_vld_i,
    input  logic [BANK_N*NW-1:0] sorted_n_i,
    input  logic [BANK_N-1:0]    sorted_err_i,
    output logic [BANK_N-1:0]    unload_start_o,
    output logic [BANK_N-1:0]    unload_done_o,
    output logic                 rd_en_o,
    output logic [BW-1:0]        rd_bank_o,
    output logic [AW-1:0]        rd_addr_o,
    input  logic [W-1:0]         rd_dat_i,
    output logic                 out_vld_r,
    output logic [W-1:0]         out_dat_r,
    output logic                 out_last_r,
    output logic                 out_err_r,
    input  logic                 out_accept_i,
    output logic                 busy_r
);
    typedef enum logic [1:0] {IDLE, EMIT, DRAIN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   rr_reg, bank_reg, grant_idx;
    logic [NW-1:0]   n_reg, addr_reg;
    logic            err_reg, grant_vld, err_push, last_rd;
    logic            inflight_reg, inflight_last_reg;
    logic            skid_vld_reg, skid_last_reg, skid_err_reg;
    logic [W-1:0]    skid_dat_reg;
    logic            pop, credit_ok, order_err;
    logic [1:0]      level;
    logic            in_vld, in_last, in_err;
    logic [W-1:0]    in_dat;
    logic [NW-1:0]   bank_n [BANK_N];

    for (genvar gi = 0; gi < BANK_N; gi++) begin : g_bank_n
        assign bank_n[gi] = sorted_n_i[gi*NW +: NW];
    end

    // Output buffer is the out_* stage plus one skid slot; reads are only issued when a slot is guaranteed.
    assign pop       = out_vld_r & out_accept_i;
    assign level     = {1'b0, out_vld_r} + {1'b0, skid_vld_reg} + {1'b0, inflight_reg};
    assign credit_ok = (level - {1'b0, pop}) < 2'd2;
    assign last_rd   = (addr_reg + NW'(1)) == n_reg;
    assign rd_bank_o = bank_reg;
    assign rd_addr_o = addr_reg[AW-1:0];

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < BANK_N; i++) begin
            if (!grant_vld && sorted_vld_i[(int'(rr_reg) + i) % BANK_N]) begin
                grant_vld = 1'b1;
                grant_idx = BW'((int'(rr_reg) + i) % BANK_N);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        rd_en_o    = 1'b0;
        err_push   = 1'b0;
        case (state_reg)
            IDLE: if (grant_vld) state_next = EMIT;
            EMIT: begin
                if (err_reg) begin
                    if (credit_ok) begin
                        err_push   = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (n_reg == '0) begin
                    state_next = DONE;
                end else if (credit_ok) begin
                    rd_en_o = 1'b1;
                    if (last_rd) state_next = DRAIN;
                end
            end
            DRAIN: if (!out_vld_r && !skid_vld_reg && !inflight_reg) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef VERT_UCODE_QUICKSORT_UNLOAD_CHECK_EN
    logic [W-1:0] prev_reg;
    logic         first_reg;

    assign order_err = inflight_reg && !first_reg && (rd_dat_i < prev_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg  <= '0;
            first_reg <= 1'b1;
        end else if (state_reg == IDLE && grant_vld) begin
            first_reg <= 1'b1;
        end else if (inflight_reg) begin
            prev_reg  <= rd_dat_i;
            first_reg <= 1'b0;
        end
    end
`else
    assign order_err = 1'b0;
`endif

    // Incoming beat: returning RAM data, or the synthetic beat of an errored bank.
    always_comb begin
        in_vld  = inflight_reg | err_push;
        in_dat  = inflight_reg ? rd_dat_i : '0;
        in_last = inflight_reg ? inflight_last_reg : 1'b1;
        in_err  = err_reg | order_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            busy_r            <= 1'b0;
            rr_reg            <= '0;
            bank_reg          <= '0;
            n_reg             <= '0;
            err_reg           <= 1'b0;
            addr_reg          <= '0;
            unload_start_o    <= '0;
            unload_done_o     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            skid_vld_reg      <= 1'b0;
            skid_dat_reg      <= '0;
            skid_last_reg     <= 1'b0;
            skid_err_reg      <= 1'b0;
            out_vld_r         <= 1'b0;
            out_dat_r         <= '0;
            out_last_r        <= 1'b0;
            out_err_r         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            busy_r         <= (state_next != IDLE);
            unload_start_o <= '0;
            unload_done_o  <= '0;
            if (state_reg == IDLE && grant_vld) begin
                bank_reg       <= grant_idx;
                n_reg          <= bank_n[grant_idx];
                err_reg        <= sorted_err_i[grant_idx];
                addr_reg       <= '0;
                rr_reg         <= (grant_idx == BW'(BANK_N - 1)) ? '0 : grant_idx + BW'(1);
                unload_start_o <= BANK_N'(1) << grant_idx;
            end
            if (state_next == DONE) unload_done_o <= BANK_N'(1) << bank_reg;
            if (rd_en_o) addr_reg <= addr_reg + NW'(1);
            inflight_reg      <= rd_en_o;
            inflight_last_reg <= rd_en_o & last_rd;

            if (!out_vld_r || pop) begin
                if (skid_vld_reg) begin
                    out_vld_r    <= 1'b1;
                    out_dat_r    <= skid_dat_reg;
                    out_last_r   <= skid_last_reg;
                    out_err_r    <= skid_err_reg;
                    skid_vld_reg <= in_vld;
                    if (in_vld) begin
                        skid_dat_reg  <= in_dat;
                        skid_last_reg <= in_last;
                        skid_err_reg  <= in_err;
                    end
                end else begin
                    out_vld_r  <= in_vld;
                    out_dat_r  <= in_vld ? in_dat : '0;
                    out_last_r <= in_vld & in_last;
                    out_err_r  <= in_vld & in_err;
                end
            end else if (in_vld) begin
                skid_vld_reg  <= 1'b1;
                skid_dat_reg  <= in_dat;
                skid_last_reg <= in_last;
                skid_err_reg  <= in_err;
            end
        end
    end
endmodule
